me_job_scheduler: RTL and testbench

//  Shares one motion-estimation engine (16x16 ref block, 32x32 search window) among NUM_REQ requesters.

---
 rtl/me_job_scheduler.sv | 141 ++++++++++++++
 tb/tb_me_job_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/me_job_scheduler.sv
// rtl/me_job_scheduler.sv - round-robin job scheduler sharing one motion-estimation engine
module me_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int BASE_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*BASE_W-1:0] req_ref_base,
  input  logic [NUM_REQ*BASE_W-1:0] req_srch_base,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [7:0]                rsp_dist,
  output logic [3:0]                rsp_mx,
  output logic [3:0]                rsp_my,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      me_start,
  input  logic                      me_completed,
  input  logic [7:0]                me_best_dist,
  input  logic [3:0]                me_motion_x,
  input  logic [3:0]                me_motion_y,
  input  logic [7:0]                me_addr_r,
  input  logic [9:0]                me_addr_s1,
  input  logic [9:0]                me_addr_s2,
  output logic [BASE_W-1:0]         mem_addr_r,
  output logic [BASE_W-1:0]         mem_addr_s1,
  output logic [BASE_W-1:0]         mem_addr_s2
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] RR_INIT = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      id;
  logic [BASE_W-1:0]   ref_base;
  logic [BASE_W-1:0]   srch_base;
  logic [WDW-1:0]      watchdog;

  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_id;
  logic [IDW-1:0]      cand;
  logic                found;

  // Round-robin pick: first pending requester after the last one served
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        found       = 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign rsp_id    = id;

  // Engine-local addresses relocated by the latched job bases; wraps modulo 2^BASE_W
  assign mem_addr_r  = ref_base  + BASE_W'(me_addr_r);
  assign mem_addr_s1 = srch_base + BASE_W'(me_addr_s1);
  assign mem_addr_s2 = srch_base + BASE_W'(me_addr_s2);

  // Job FSM: grant, start pulse, run with watchdog, hold response until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= RR_INIT;
      id          <= '0;
      ref_base    <= '0;
      srch_base   <= '0;
      watchdog    <= '0;
      me_start    <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_dist    <= '0;
      rsp_mx      <= '0;
      rsp_my      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id        <= grant_id;
            ref_base  <= req_ref_base[int'(grant_id)*BASE_W +: BASE_W];
            srch_base <= req_srch_base[int'(grant_id)*BASE_W +: BASE_W];
            me_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          me_start <= 1'b0;
          watchdog <= '0;
          state    <= RUN;
        end
        RUN: begin
          watchdog <= watchdog + WDW'(1);
          if (me_completed) begin
            rsp_dist    <= me_best_dist;
            rsp_mx      <= me_motion_x;
            rsp_my      <= me_motion_y;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (watchdog == WD_LAST) begin
            rsp_dist    <= 8'hFF;
            rsp_mx      <= 4'h0;
            rsp_my      <= 4'h0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_job_scheduler.sv
// tb/tb_me_job_scheduler.sv - directed self-checking bench for me_job_scheduler
module tb_me_job_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_ref_base;
  logic [63:0] req_srch_base;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_dist;
  logic [3:0]  rsp_mx;
  logic [3:0]  rsp_my;
  logic        rsp_timeout;
  logic        busy;
  logic        me_start;
  logic        me_completed;
  logic [7:0]  me_best_dist;
  logic [3:0]  me_motion_x;
  logic [3:0]  me_motion_y;
  logic [7:0]  me_addr_r;
  logic [9:0]  me_addr_s1;
  logic [9:0]  me_addr_s2;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_addr_s1;
  logic [15:0] mem_addr_s2;

  int nvec = 0;
  int nerr = 0;

  me_job_scheduler #(.NUM_REQ(4), .IDW(2), .BASE_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ref_base(req_ref_base), .req_srch_base(req_srch_base),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_dist(rsp_dist), .rsp_mx(rsp_mx), .rsp_my(rsp_my),
    .rsp_timeout(rsp_timeout), .busy(busy), .me_start(me_start),
    .me_completed(me_completed), .me_best_dist(me_best_dist),
    .me_motion_x(me_motion_x), .me_motion_y(me_motion_y),
    .me_addr_r(me_addr_r), .me_addr_s1(me_addr_s1), .me_addr_s2(me_addr_s2),
    .mem_addr_r(mem_addr_r), .mem_addr_s1(mem_addr_s1), .mem_addr_s2(mem_addr_s2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          exp_order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  one_hot;

  initial begin
    reset = 1'b1; req_valid = 4'b1111; req_ref_base = '0; req_srch_base = '0;
    rsp_ready = 1'b0; me_completed = 1'b0; me_best_dist = '0;
    me_motion_x = '0; me_motion_y = '0;
    me_addr_r = '0; me_addr_s1 = '0; me_addr_s2 = '0;
    tick(); tick();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_outputs", {26'h0, rsp_valid, me_start, busy, rsp_timeout, rsp_id}, 32'h0);
    chk("reset_mem_addr_r", 32'(mem_addr_r), 32'h0);
    req_valid = 4'b0000;
    reset = 1'b0;
    tick();

    // T1: single job from requester 2
    req_ref_base[2*16 +: 16]  = 16'h1000;
    req_srch_base[2*16 +: 16] = 16'h2000;
    req_valid = 4'b0100;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("t1_start", {30'h0, me_start, busy}, 32'h3);
    me_addr_r = 8'h05; me_addr_s1 = 10'h021;
    #1;
    chk("t1_mem_addr_r", 32'(mem_addr_r), 32'h1005);
    chk("t1_mem_addr_s1", 32'(mem_addr_s1), 32'h2021);
    tick();
    chk("t1_start_gone", 32'(me_start), 32'h0);
    me_completed = 1'b1; me_best_dist = 8'h23; me_motion_x = 4'd3; me_motion_y = 4'd12;
    tick();
    me_completed = 1'b0;
    chk("t1_rsp", {rsp_valid, rsp_timeout, rsp_id, rsp_dist, rsp_mx, rsp_my},
        {1'b1, 1'b0, 2'd2, 8'h23, 4'd3, 4'd12});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_back_idle", {30'h0, rsp_valid, busy}, 32'h0);

    // T2: all requesters pending, fairness from reset
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      one_hot = 4'b0001 << exp_order[j];
      #1;
      chk("t2_grant", 32'(req_ready), 32'(one_hot));
      tick();
      chk("t2_start_pulse", 32'(me_start), 32'h1);
      tick();
      chk("t2_run_no_start", 32'(me_start), 32'h0);
      me_completed = 1'b1; me_best_dist = 8'(8'h40 + j);
      tick();
      me_completed = 1'b0;
      chk("t2_rsp", {me_start, req_ready, rsp_valid, rsp_id, rsp_dist},
          {1'b0, 4'b0000, 1'b1, 2'(exp_order[j]), 8'(8'h40 + j)});
      tick();
    end
    rsp_ready = 1'b0;

    // T3: response back-pressure holds everything
    #1;
    chk("t3_grant", 32'(req_ready), 32'h2);
    tick(); tick();
    me_completed = 1'b1; me_best_dist = 8'h5A; me_motion_x = 4'd7; me_motion_y = 4'd9;
    tick();
    me_completed = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold", {me_start, req_ready, rsp_valid, rsp_id, rsp_dist, rsp_mx, rsp_my},
          {1'b0, 4'b0000, 1'b1, 2'd1, 8'h5A, 4'd7, 4'd9});
      tick();
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    req_valid = 4'b0001;

    // T4a: watchdog abort on the 65th cycle after me_start
    #1;
    chk("t4_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("t4_start", 32'(me_start), 32'h1);
    for (int k = 1; k <= 64; k++) tick();
    chk("t4_not_yet", 32'(rsp_valid), 32'h0);
    tick();
    chk("t4_timeout_rsp", {rsp_valid, rsp_timeout, rsp_dist, rsp_mx, rsp_my},
        {1'b1, 1'b1, 8'hFF, 4'd0, 4'd0});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // T4b: completion on the final RUN cycle beats the watchdog
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    for (int k = 1; k <= 64; k++) tick();
    me_completed = 1'b1; me_best_dist = 8'h11; me_motion_x = 4'd1; me_motion_y = 4'd2;
    tick();
    me_completed = 1'b0;
    chk("t4_late_complete", {rsp_valid, rsp_timeout, rsp_dist, rsp_mx, rsp_my},
        {1'b1, 1'b0, 8'h11, 4'd1, 4'd2});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // T5: reset during RUN drops the job; stray completion ignored
    req_valid = 4'b1111;
    tick(); tick();
    req_valid = 4'b0000; me_addr_r = '0; me_addr_s1 = '0; me_addr_s2 = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    me_completed = 1'b1;
    chk("t5_all_zero", {req_ready, rsp_valid, me_start, busy, rsp_timeout, rsp_id, rsp_dist},
        18'h0);
    chk("t5_addr_zero", 32'(mem_addr_s1), 32'h0);
    tick();
    me_completed = 1'b0;
    chk("t5_stray_ignored", {30'h0, rsp_valid, busy}, 32'h0);
    req_srch_base[0 +: 16] = 16'hFFF0;
    req_valid = 4'b1111;
    #1;
    chk("t5_grant_req0", 32'(req_ready), 32'h1);

    // T6: search address wraps modulo 2^16
    tick();
    req_valid = 4'b0000;
    me_addr_s2 = 10'h3FF;
    #1;
    chk("t6_wrap", 32'(mem_addr_s2), 32'h03EF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
